// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Brief    : Shared types and constants for the clk_div_sched scheduler.
//  Revision : 1.0
// ============================================================================
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int CNT_W       = 8;
    localparam int DIV_MIN     = 2;
    localparam int DIV_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_core
//  Brief    : Period counter with registered divided clock and tick strobe.
//  Revision : 1.0
// ============================================================================
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [CNT_W-1:0] div_active,
    output logic             clk_div,
    output logic             tick,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W:0]   w_half;
    logic             w_clk_div_next;
    logic             w_tick_next;

    // Outputs are registered from the next count so they line up with the
    // cycle the count describes; a wrap or a start always lands on phase 0,
    // where both outputs are low for any legal ratio.
    always_comb begin
        w_half         = ({1'b0, div_active} + (CNT_W+1)'(1)) >> 1;
        wrap           = run && (r_cnt == div_active - CNT_W'(1));
        w_cnt_next     = '0;
        if (run && !wrap) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_clk_div_next = run && ({1'b0, w_cnt_next} >= w_half);
        w_tick_next    = run && (w_cnt_next == div_active - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt   <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            clk_div <= w_clk_div_next;
            tick    <= w_tick_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_sched
//  Brief    : Clock-enable scheduler: run/stop FSM and glitch-free ratio
//             change handshake around clk_div_core.
//  Revision : 1.0
// ============================================================================
module clk_div_sched #(
    parameter int CNT_W       = clk_div_pkg::CNT_W,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick,
    output logic             busy
);

    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] c_div_min   = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] c_div_reset = CNT_W'(DIV_DEFAULT);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_ack;
    logic             r_err;
    logic             w_run;
    logic             w_wrap;
    logic             w_take;
    logic             w_bad;
    logic             w_apply_now;

    assign w_run       = (r_state != IDLE);
    // The cycle showing ack/err is the requester's chance to drop div_req.
    assign w_take      = div_req && !r_ack && !r_err && !r_pend_vld;
    assign w_bad       = (div_val < c_div_min);
    assign w_apply_now = (r_state == IDLE) || w_wrap;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (en) w_state_next = RUN;
            RUN:      if (!en) w_state_next = STOPPING;
            STOPPING: begin
                if (en)          w_state_next = RUN;
                else if (w_wrap) w_state_next = IDLE;
            end
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_div_active <= c_div_reset;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            if (w_take && w_bad) begin
                r_err <= 1'b1;
            end else if (w_take && w_apply_now) begin
                r_div_active <= div_val;
                r_ack        <= 1'b1;
            end else if (w_take) begin
                r_pend     <= div_val;
                r_pend_vld <= 1'b1;
            end else if (r_pend_vld && w_wrap) begin
                r_div_active <= r_pend;
                r_pend_vld   <= 1'b0;
                r_ack        <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .clr        (!reset),
        .run        (w_run),
        .div_active (r_div_active),
        .clk_div    (clk_div),
        .tick       (tick),
        .wrap       (w_wrap)
    );

    assign div_ack = r_ack;
    assign cfg_err = r_err;
    assign busy    = w_run;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_sched
//  Brief    : Directed self-checking bench for clk_div_sched.
//  Revision : 1.0
// ============================================================================
module tb_clk_div_sched;

    logic       clk;
    logic       reset;
    logic       en;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       cfg_err;
    logic       clk_div;
    logic       tick;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_sched dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .cfg_err (cfg_err),
        .clk_div (clk_div),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {busy, clk_div, tick, div_ack, cfg_err};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t {busy,clk_div,tick,ack,err} got=%b exp=%b",
                     tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks cnt running cycles of ratio n starting at phase p0; ack_i/err_i
    // are the loop indices where those pulses are due (-1 for none).
    task automatic run_chk(input string tag, input int n, input int p0, input int cnt,
                           input int ack_i, input int err_i);
        int p;
        logic [4:0] e;
        for (int i = 0; i < cnt; i++) begin
            p = (p0 + i) % n;
            e = {1'b1, (p >= (n + 1) / 2), (p == n - 1), (i == ack_i), (i == err_i)};
            check(tag, obs(), e);
            step();
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 8'd0;
        step(); step();
        check("reset", obs(), 5'b00000);

        reset = 1'b1; en = 1'b1; step();
        run_chk("n6_default", 6, 0, 18, -1, -1);

        run_chk("n6_pre_req", 6, 0, 2, -1, -1);
        div_req = 1'b1; div_val = 8'd3;
        run_chk("n6_pend3", 6, 2, 4, -1, -1);
        run_chk("n3_ack", 3, 0, 1, 0, -1);
        div_req = 1'b0;
        run_chk("n3", 3, 1, 5, -1, -1);

        div_req = 1'b1; div_val = 8'd1;
        run_chk("err_val1", 3, 0, 2, -1, 1);
        div_req = 1'b0;
        div_req = 1'b1; div_val = 8'd0;
        run_chk("err_val0", 3, 2, 2, -1, 1);
        div_req = 1'b0;
        run_chk("n3_kept", 3, 1, 6, -1, -1);

        div_req = 1'b1; div_val = 8'd6;
        run_chk("n3_pend6", 3, 1, 2, -1, -1);
        run_chk("n6_ack", 6, 0, 1, 0, -1);
        div_req = 1'b0;
        en = 1'b0;
        run_chk("stop_k7", 6, 1, 5, -1, -1);
        for (int i = 0; i < 3; i++) begin
            check("idle_after_stop", obs(), 5'b00000);
            step();
        end

        en = 1'b1; step();
        run_chk("rerun", 6, 0, 7, -1, -1);
        en = 1'b0;
        run_chk("rerun_en_lo", 6, 1, 2, -1, -1);
        en = 1'b1;
        run_chk("rerun_en_hi", 6, 3, 9, -1, -1);

        en = 1'b0;
        run_chk("stop2", 6, 0, 6, -1, -1);
        check("idle2", obs(), 5'b00000);
        div_req = 1'b1; div_val = 8'd4; step();
        check("idle_ack4", obs(), 5'b00010);
        div_req = 1'b0; en = 1'b1; step();
        run_chk("n4", 4, 0, 12, -1, -1);

        en = 1'b0;
        run_chk("stop3", 4, 0, 4, -1, -1);
        check("idle3", obs(), 5'b00000);
        en = 1'b1; div_req = 1'b1; div_val = 8'd5; step();
        run_chk("n5_ack", 5, 0, 1, 0, -1);
        div_req = 1'b0;
        run_chk("n5", 5, 1, 9, -1, -1);

        en = 1'b0; div_req = 1'b1; div_val = 8'd2;
        run_chk("stop_pend2", 5, 0, 5, -1, -1);
        check("stop_pend_ack", obs(), 5'b00010);
        div_req = 1'b0; step();
        check("idle4", obs(), 5'b00000);
        en = 1'b1; step();
        run_chk("n2", 2, 0, 8, -1, -1);

        div_req = 1'b1; div_val = 8'd7;
        run_chk("n2_pend7", 2, 0, 2, -1, -1);
        run_chk("n7_ack", 7, 0, 1, 0, -1);
        div_req = 1'b0;
        div_req = 1'b1; div_val = 8'd9;
        run_chk("n7_pend9", 7, 1, 3, -1, -1);
        reset = 1'b0;
        run_chk("n7_rst_cycle", 7, 4, 1, -1, -1);
        check("rst_mid", obs(), 5'b00000);
        reset = 1'b1; div_req = 1'b0; step();
        run_chk("after_rst_n6", 6, 0, 12, -1, -1);

        div_req = 1'b1; div_val = 8'd255;
        run_chk("n6_pend255", 6, 0, 6, -1, -1);
        run_chk("n255_ack", 255, 0, 1, 0, -1);
        div_req = 1'b0;
        run_chk("n255", 255, 1, 256, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
